// File: rtl/pulse_catcher_pkg.sv
// Shared types and default constants for the pulse catcher and its bus interface.
package pulse_catcher_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        QUALIFY = 3'd1,
        ACTIVE  = 3'd2,
        STUCK   = 3'd3,
        REARM   = 3'd4
    } state_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_MIN_HIGH    = 4;
    localparam int DEF_MAX_HIGH    = 64;
    localparam int DEF_MIN_LOW     = 2;
    localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/pulse_catcher_if.sv
// Level-pulse input, count clear and status outputs of the pulse catcher.
interface pulse_catcher_if
    import pulse_catcher_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             signal;
    logic             countClear;
    logic             pulse;
    logic             stuck;
    logic             busy;
    logic [CNT_W-1:0] pulseCount;

    modport master (
        output signal,
        output countClear,
        input  pulse,
        input  stuck,
        input  busy,
        input  pulseCount
    );

    modport slave (
        input  signal,
        input  countClear,
        output pulse,
        output stuck,
        output busy,
        output pulseCount
    );
endinterface

// File: rtl/pulse_catcher_sync_chain.sv
// Generic N-flop synchronizer for asynchronous single-bit inputs, reset to 0.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];
endmodule

// File: rtl/pulse_catcher.sv
// Synchronizes a stretched level pulse, qualifies its width and emits one strobe
// per qualified pulse, with stuck-high detection and a saturating strobe count.
module pulse_catcher
    import pulse_catcher_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int MIN_HIGH    = DEF_MIN_HIGH,
    parameter int MAX_HIGH    = DEF_MAX_HIGH,
    parameter int MIN_LOW     = DEF_MIN_LOW,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic           clk,
    input  logic           reset,
    pulse_catcher_if.slave bus
);
    localparam int HI_W = $clog2(MAX_HIGH + 1);
    localparam int LO_W = $clog2(MIN_LOW + 1);

    localparam logic [HI_W-1:0] HI_ONE  = HI_W'(1);
    localparam logic [HI_W-1:0] HI_QUAL = HI_W'(MIN_HIGH);
    localparam logic [HI_W-1:0] HI_MAX  = HI_W'(MAX_HIGH);
    localparam logic [LO_W-1:0] LO_ONE  = LO_W'(1);
    localparam logic [LO_W-1:0] LO_ARM  = LO_W'(MIN_LOW);

    logic             s;
    state_e           state_q, state_d;
    logic [HI_W-1:0]  hi_q, hi_d, hi_inc;
    logic [LO_W-1:0]  lo_q, lo_d, lo_inc;
    logic             pulse_q, pulse_d;
    logic             stuck_q, stuck_d;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (reset),
        .d_i (bus.signal),
        .q_o (s)
    );

    assign hi_inc = hi_q + HI_ONE;
    assign lo_inc = lo_q + LO_ONE;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pulse_d = 1'b0;
        stuck_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s) begin
                    hi_d = HI_ONE;
                    if (MIN_HIGH == 1) begin
                        state_d = ACTIVE;
                        pulse_d = 1'b1;
                    end else begin
                        state_d = QUALIFY;
                    end
                end
            end
            QUALIFY: begin
                if (s) begin
                    hi_d = hi_inc;
                    if (hi_inc == HI_QUAL) begin
                        state_d = ACTIVE;
                        pulse_d = 1'b1;
                    end
                end else begin
                    hi_d    = '0;
                    state_d = IDLE;
                end
            end
            ACTIVE, STUCK: begin
                if (s) begin
                    // hiCount saturates at MAX_HIGH once STUCK is entered
                    if (state_q == STUCK) begin
                        stuck_d = 1'b1;
                    end else begin
                        hi_d = hi_inc;
                        if (hi_inc == HI_MAX) begin
                            state_d = STUCK;
                            stuck_d = 1'b1;
                        end
                    end
                end else begin
                    hi_d = '0;
                    if (MIN_LOW == 1) begin
                        state_d = IDLE;
                    end else begin
                        state_d = REARM;
                        lo_d    = LO_ONE;
                    end
                end
            end
            REARM: begin
                if (!s) begin
                    lo_d = lo_inc;
                    if (lo_inc == LO_ARM) begin
                        state_d = IDLE;
                        lo_d    = '0;
                    end
                end else begin
                    lo_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                hi_d    = '0;
                lo_d    = '0;
            end
        endcase
    end

    // A clear coincident with a new strobe counts that strobe
    always_comb begin
        cnt_d = cnt_q;
        if (bus.countClear) begin
            cnt_d = pulse_d ? CNT_W'(1) : '0;
        end else if (pulse_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            pulse_q <= 1'b0;
            stuck_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pulse_q <= pulse_d;
            stuck_q <= stuck_d;
            busy_q  <= (state_d != IDLE);
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pulse      = pulse_q;
    assign bus.stuck      = stuck_q;
    assign bus.busy       = busy_q;
    assign bus.pulseCount = cnt_q;
endmodule
